reg_arb_mux: RTL
================

# reg_arb_mux

Registered N-channel round-robin arbitrating multiplexer with valid/ready handshakes on every input and on the output. It is the parametrised successor to the plain combinational register muxes: it selects among `CHANNELS` requesters by fair rotation and buffers the winner in a one-entry output register. The output also reports the source index. It sits between multiple producers (register-file read ports, fetch/load paths) and a shared single consumer such as a bus or ALU operand port.

## Interface
- `DATA_BITS`, 8, width of each data word.
- `CHANNELS`, 4, number of input channels; legal range 2..16.
- `SEL_BITS`, `$clog2(CHANNELS)`, width of the source index (derived; do not override).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  `CHANNELS*DATA_BITS`  packed inputs; channel i occupies bits `[i*DATA_BITS +: DATA_BITS]`.
- `in_valid`  in  `CHANNELS`  per-channel request/valid.
- `in_ready`  out  `CHANNELS`  per-channel accept; at most one bit set per cycle.
- `out_data`  out  `DATA_BITS`  registered selected word.
- `out_sel`  out  `SEL_BITS`  index of the channel that supplied `out_data`.
- `out_valid`  out  1  `out_data`/`out_sel` hold a word.
- `out_ready`  in  1  consumer accepts the word this cycle.

## Operation
- One clock domain; reset is synchronous and active-high.
- Transfer semantics:
  - An input transfer occurs on channel i when `in_valid[i] && in_ready[i]` at a rising edge.
  - An output transfer occurs when `out_valid && out_ready` at a rising edge.
- The output register is free when `!out_valid || out_ready`.
- Arbitration (combinational):
  - State `last` (SEL_BITS) holds the index of the last granted channel.
  - Search channels `last+1, last+2, …` modulo `CHANNELS`, wrapping past `CHANNELS-1` to 0.
  - The first channel with `in_valid` set is the grant.
  - With no valid inputs there is no grant.
- `in_ready[g]` = grant[g] && output register free. All other `in_ready` bits are 0.
- On an input transfer from channel g:
  - `out_data` <= channel g data.
  - `out_sel` <= g.
  - `out_valid` <= 1.
  - `last` <= g.
- On an output transfer with no simultaneous input transfer: `out_valid` <= 0. `out_data` and `out_sel` hold their previous values.
- Simultaneous drain and fill in the same cycle: the new word replaces the old one and `out_valid` stays 1. This gives full throughput of one word per cycle.
- When `out_valid && !out_ready` (stall):
  - All `in_ready` are 0.
  - The output register and `last` hold.
- `last` changes only on an input transfer. A channel that withdraws its request does not advance rotation.
- Fairness: with all channels continuously valid and `out_ready`=1, grants cycle 0,1,…,CHANNELS-1,0,…. Each channel waits at most `CHANNELS-1` transfers.
- A lone requester is granted every free cycle.
- Upstream must hold `in_valid`/`in_data` stable until accepted. The block does not check this; if a channel drops valid, the grant simply moves on.
- `in_ready` depends combinationally on `in_valid` and `out_ready`. Producers must not make `in_valid` depend on `in_ready`.
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_sel`=0.
  - `last`=`CHANNELS-1`, so channel 0 has first priority.
  - All `in_ready`=0 while `reset` is high.
- Reset asserted mid-operation discards the held word. No transfer occurs on that edge.

## Timing
- Latency: an input accepted at edge N appears on `out_data`/`out_valid` after edge N, i.e. in cycle N+1.
- Throughput: 1 word/cycle when `out_ready` is held high.
- Combinational paths:
  - `in_valid` -> `in_ready`.
  - `out_ready` -> `in_ready`.
- No combinational path from `in_data` to any output.
- `out_data`, `out_sel` and `out_valid` come directly from flops.
- First possible transfer: the first edge after `reset` deasserts.

## Test plan
- Reset, then DATA_BITS=8, CHANNELS=4, all `in_valid`=1 (data 0x10,0x21,0x32,0x43), `out_ready`=1 -> `out_sel` sequence 0,1,2,3,0; `out_data` 0x10,0x21,0x32,0x43,0x10; `out_valid` continuously 1 from the first cycle after accept.
- Only channel 2 valid (0xA5), `out_ready`=1 for 4 cycles -> `in_ready`=0100 every cycle; four transfers with `out_sel`=2, `out_data`=0xA5.
- Word held in output with `out_ready`=0 for 3 cycles while channels 1 and 3 are valid -> `in_ready`=0000; `out_data` and `out_sel` stable. On `out_ready`=1, channel 1 is accepted the same cycle and appears next cycle (drain and fill, no bubble).
- `last`=3, channels 0 and 3 valid -> channel 0 granted (wrap). Next grant is channel 3, then channel 0.
- `reset` asserted while `out_valid`=1 and all inputs valid -> next cycle `out_valid`=0, `out_data`=0, `in_ready`=0. After release, the first grant is channel 0.
- CHANNELS=2 and CHANNELS=16 builds -> `SEL_BITS` of 1 and 4. All-valid rotation covers every index and wraps from `CHANNELS-1` to 0.

Source files
------------

// File: rtl/reg_arb_mux.sv
// reg_arb_mux: round-robin arbitrating multiplexer with a one-entry registered output.
// CHANNELS valid/ready producers share one valid/ready consumer; the winner's word and
// its source index are captured in output flops.
module reg_arb_mux #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CHANNELS  = 4,
    // Derived; do not override.
    parameter int unsigned SEL_BITS  = $clog2(CHANNELS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS*DATA_BITS-1:0] in_data,
    input  logic [CHANNELS-1:0]           in_valid,
    output logic [CHANNELS-1:0]           in_ready,
    output logic [DATA_BITS-1:0]          out_data,
    output logic [SEL_BITS-1:0]           out_sel,
    output logic                          out_valid,
    input  logic                          out_ready
);

    // Rotation pointer: index of the most recently granted channel.
    logic [SEL_BITS-1:0]  last_q;
    logic [DATA_BITS-1:0] data_q;
    logic [SEL_BITS-1:0]  sel_q;
    logic                 valid_q;

    logic                 grant_valid;
    logic [SEL_BITS-1:0]  grant_idx;
    logic [SEL_BITS-1:0]  cand;
    logic                 free;
    logic                 accept;
    logic [DATA_BITS-1:0] chan_data [CHANNELS];

    // Unpack the flat data bus into one word per channel.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            chan_data[i] = in_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    // Search last+1, last+2, ... (mod CHANNELS); the first valid channel wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            cand = SEL_BITS'((32'(last_q) + k) % CHANNELS);
            if (!grant_valid && in_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Output register can take a word when empty or being drained this cycle.
    always_comb begin
        free     = !valid_q || out_ready;
        accept   = grant_valid && free && !reset;
        in_ready = '0;
        if (accept) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Capture the winner; a drain without a fill empties the register but keeps data/sel.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            last_q  <= SEL_BITS'(CHANNELS - 1);
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= chan_data[grant_idx];
            sel_q   <= grant_idx;
            last_q  <= grant_idx;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule
